// File: rtl/vga_pkg.sv
// Shared VGA scan-out definitions: default 640x480@60 timing, RGB332 pixel type
// and the RGB332 -> RGB888 expansion used by the output stage.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
   localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

   // Wide enough for any realistic line/frame count.
   localparam int CNT_W = 12;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   function automatic rgb888_t expand332(input rgb332_t p);
      rgb888_t c;
      c.r = {p.r, p.r, p.r[2:1]};
      c.g = {p.g, p.g, p.g[2:1]};
      c.b = {p.b, p.b, p.b, p.b};
      return c;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider and horizontal/vertical scan counters with raw
// (unpipelined) sync and active-area flags decoded from the counters.
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic             clk,
   input  logic             reset,
   output logic             tick,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             hs,
   output logic             vs,
   output logic             active
);

   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SS    = H_ACTIVE + H_FP;
   localparam int H_SE    = H_SS + H_SYNC;
   localparam int V_SS    = V_ACTIVE + V_FP;
   localparam int V_SE    = V_SS + V_SYNC;

   logic [DIV_W-1:0] div_reg;
   logic [CNT_W-1:0] h_cnt_reg;
   logic [CNT_W-1:0] v_cnt_reg;

   assign tick = (div_reg == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         div_reg   <= '0;
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else if (tick) begin
         div_reg <= '0;
         if (h_cnt_reg == CNT_W'(H_TOT - 1)) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == CNT_W'(V_TOT - 1)) ? '0 : v_cnt_reg + 1'b1;
         end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
         end
      end else begin
         div_reg <= div_reg + 1'b1;
      end
   end

   assign h_cnt  = h_cnt_reg;
   assign v_cnt  = v_cnt_reg;
   assign hs     = !((h_cnt_reg >= CNT_W'(H_SS)) && (h_cnt_reg < CNT_W'(H_SE)));
   assign vs     = !((v_cnt_reg >= CNT_W'(V_SS)) && (v_cnt_reg < CNT_W'(V_SE)));
   assign active = (h_cnt_reg < CNT_W'(H_ACTIVE)) && (v_cnt_reg < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/vga_dmem_reader.sv
// Scans an upscaled RGB332 image out of data-memory read port 1 onto VGA.
// Two tick-enabled stages: address/flags, then byte select and colour expand.
module vga_dmem_reader
   import vga_pkg::*;
#(
   parameter int          CLK_DIV   = 2,
   parameter int          H_ACTIVE  = H_ACTIVE_DEF,
   parameter int          H_FP      = H_FP_DEF,
   parameter int          H_SYNC    = H_SYNC_DEF,
   parameter int          H_BP      = H_BP_DEF,
   parameter int          V_ACTIVE  = V_ACTIVE_DEF,
   parameter int          V_FP      = V_FP_DEF,
   parameter int          V_SYNC    = V_SYNC_DEF,
   parameter int          V_BP      = V_BP_DEF,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
   parameter int          IMG_W     = 32,
   parameter int          IMG_H     = 32,
   parameter int          SCALE     = 4,
   parameter logic [7:0]  BG_COLOR  = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] addr1,
   input  logic [31:0] rd1,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_start
);

   localparam int SCALE_SH = (SCALE > 1) ? $clog2(SCALE) : 0;

   logic             tick;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             raw_hs;
   logic             raw_vs;
   logic             raw_active;

   vga_timing #(
      .CLK_DIV  (CLK_DIV),
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .h_cnt  (h_cnt),
      .v_cnt  (v_cnt),
      .hs     (raw_hs),
      .vs     (raw_vs),
      .active (raw_active)
   );

   // Stage-1 address arithmetic, all at 32 bits.
   logic [31:0] h32;
   logic [31:0] v32;
   logic [31:0] ix;
   logic [31:0] iy;
   logic [31:0] addr_next;
   logic        in_img;
   logic        first_pix;

   assign h32 = 32'(h_cnt);
   assign v32 = 32'(v_cnt);

   if ((SCALE & (SCALE - 1)) == 0) begin : g_shift
      assign ix = h32 >> SCALE_SH;
      assign iy = v32 >> SCALE_SH;
   end else begin : g_div
      assign ix = h32 / 32'(SCALE);
      assign iy = v32 / 32'(SCALE);
   end

   assign in_img    = (h32 < 32'(IMG_W * SCALE)) && (v32 < 32'(IMG_H * SCALE));
   assign addr_next = BASE_ADDR + iy * 32'(IMG_W) + {ix[31:2], 2'b00};
   assign first_pix = (h_cnt == '0) && (v_cnt == '0);

   logic [31:0] addr_reg;
   logic [1:0]  bsel_reg;
   logic        in_img_reg;
   logic        active_reg;
   logic        hs1_reg;
   logic        vs1_reg;
   logic        first_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_reg   <= BASE_ADDR;
         bsel_reg   <= '0;
         in_img_reg <= 1'b0;
         active_reg <= 1'b0;
         hs1_reg    <= 1'b1;
         vs1_reg    <= 1'b1;
         first_reg  <= 1'b0;
      end else if (tick) begin
         // Outside the window the address is parked so the memory port stays quiet.
         if (in_img) begin
            addr_reg <= addr_next;
         end
         bsel_reg   <= ix[1:0];
         in_img_reg <= in_img;
         active_reg <= raw_active;
         hs1_reg    <= raw_hs;
         vs1_reg    <= raw_vs;
         first_reg  <= first_pix;
      end
   end

   // Stage 2: rd1 is combinational on the registered addr1.
   rgb332_t pix;
   rgb888_t rgb_next;

   always_comb begin
      pix      = rgb332_t'(BG_COLOR);
      rgb_next = '0;
      if (in_img_reg) begin
         pix = rgb332_t'(rd1[{bsel_reg, 3'b000} +: 8]);
      end
      if (active_reg) begin
         rgb_next = expand332(pix);
      end
   end

   rgb888_t rgb_reg;
   logic    hs2_reg;
   logic    vs2_reg;
   logic    blank_n_reg;
   logic    frame_start_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_reg         <= '0;
         hs2_reg         <= 1'b1;
         vs2_reg         <= 1'b1;
         blank_n_reg     <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         frame_start_reg <= tick && first_reg;
         if (tick) begin
            rgb_reg     <= rgb_next;
            hs2_reg     <= hs1_reg;
            vs2_reg     <= vs1_reg;
            blank_n_reg <= active_reg;
         end
      end
   end

   assign addr1       = addr_reg;
   assign vga_hs      = hs2_reg;
   assign vga_vs      = vs2_reg;
   assign vga_blank_n = blank_n_reg;
   assign vga_r       = rgb_reg.r;
   assign vga_g       = rgb_reg.g;
   assign vga_b       = rgb_reg.b;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_dmem_reader.sv
// Scoreboard bench for vga_dmem_reader on a shrunken raster (56x18 ticks per frame)
// so full frames and a mid-frame reset fit in a few thousand clocks.
module tb_vga_dmem_reader;

   localparam int HT    = 56;
   localparam int VT    = 18;
   localparam int FRAME = HT * VT;

   localparam int F_RGB   = 0;
   localparam int F_BLANK = 1;
   localparam int F_HS    = 2;
   localparam int F_VS    = 3;
   localparam int F_ADDR  = 4;
   localparam int F_FS    = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr1;
   logic [31:0] rd1;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_blank_n;
   logic [7:0]  vga_r;
   logic [7:0]  vga_g;
   logic [7:0]  vga_b;
   logic        frame_start;

   logic [31:0] ram [0:1023];
   assign rd1 = ram[addr1[11:2]];

   vga_dmem_reader #(
      .CLK_DIV   (2),
      .H_ACTIVE  (40),
      .H_FP      (4),
      .H_SYNC    (8),
      .H_BP      (4),
      .V_ACTIVE  (12),
      .V_FP      (2),
      .V_SYNC    (2),
      .V_BP      (2),
      .BASE_ADDR (32'h0000_0800),
      .IMG_W     (8),
      .IMG_H     (2),
      .SCALE     (4),
      .BG_COLOR  (8'h49)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .addr1       (addr1),
      .rd1         (rd1),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          t;
      int          f;
      logic [31:0] v;
      string       n;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   // Bench-side tick counter: reset makes a compare point at tick 0.
   int   bdiv = 0;
   int   tick_no = 0;
   logic cmp_pt = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         bdiv    <= 0;
         tick_no <= 0;
         cmp_pt  <= 1'b1;
      end else if (bdiv == 1) begin
         bdiv    <= 0;
         tick_no <= tick_no + 1;
         cmp_pt  <= 1'b1;
      end else begin
         bdiv   <= bdiv + 1;
         cmp_pt <= 1'b0;
      end
   end

   function automatic logic [31:0] sample(input int f);
      case (f)
         F_RGB:   return {8'h00, vga_r, vga_g, vga_b};
         F_BLANK: return {31'd0, vga_blank_n};
         F_HS:    return {31'd0, vga_hs};
         F_VS:    return {31'd0, vga_vs};
         F_ADDR:  return addr1;
         default: return {31'd0, frame_start};
      endcase
   endfunction

   // Monitor: compares every expectation due at this tick; frame_start must be low between ticks.
   always @(negedge clk) begin
      if (cmp_pt) begin
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].t == tick_no) begin
               logic [31:0] got;
               got = sample(sb[i].f);
               n_checks++;
               if (got !== sb[i].v) begin
                  n_fails++;
                  $display("FAIL %s tick %0d: got %h expected %h", sb[i].n, tick_no, got, sb[i].v);
               end else begin
                  $display("ok   %s tick %0d: %h", sb[i].n, tick_no, got);
               end
               sb.delete(i);
            end
         end
      end else begin
         n_checks++;
         if (frame_start !== 1'b0) begin
            n_fails++;
            $display("FAIL frame_start_width tick %0d: got %b expected 0", tick_no, frame_start);
         end
      end
   end

   task automatic push(input int t, input int f, input logic [31:0] v, input string n);
      exp_t e;
      e.t = t; e.f = f; e.v = v; e.n = n;
      sb.push_back(e);
   endtask

   // Expectation for pixel (h,v) of frame fr: addr1 reflects it 1 tick later, outputs 2 ticks later.
   task automatic ex(input int h, input int v, input int fr, input int f,
                     input logic [31:0] val, input string n);
      int p;
      p = fr * FRAME + v * HT + h;
      push(p + ((f == F_ADDR) ? 1 : 2), f, val, n);
   endtask

   task automatic push_reset_vals();
      push(0, F_ADDR,  32'h800, "rst_addr1");
      push(0, F_HS,    32'd1,   "rst_hs");
      push(0, F_VS,    32'd1,   "rst_vs");
      push(0, F_BLANK, 32'd0,   "rst_blank_n");
      push(0, F_RGB,   32'd0,   "rst_rgb");
      push(0, F_FS,    32'd0,   "rst_frame_start");
   endtask

   task automatic wait_tick(input int t);
      int guard;
      guard = 0;
      while (tick_no < t && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (tick_no < t) begin
         n_fails++;
         $display("FAIL wait_tick: reached %0d expected %0d", tick_no, t);
      end
   endtask

   task automatic flush(input string phase);
      foreach (sb[i]) begin
         n_checks++;
         n_fails++;
         $display("FAIL %s %s: not observed, expected %h at tick %0d", phase, sb[i].n, sb[i].v, sb[i].t);
      end
      sb.delete();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
      ram[10'h200] = 32'hE01C_03FF;   // row 0, pixels 0..3
      ram[10'h201] = 32'h0000_0092;   // row 0, pixel 4
      ram[10'h202] = 32'h1122_33C4;   // row 1, pixels 0..3

      push_reset_vals();
      ex(0, 0, 0, F_ADDR, 32'h800, "addr_0_0");
      ex(0, 0, 0, F_FS,   32'd1,   "frame_start_0");
      push(3, F_FS, 32'd0, "frame_start_off");
      ex(0,  0, 0, F_RGB, 32'hFFFFFF, "rgb_h0");
      ex(3,  0, 0, F_RGB, 32'hFFFFFF, "rgb_h3");
      ex(4,  0, 0, F_RGB, 32'h0000FF, "rgb_h4_blue");
      ex(7,  0, 0, F_RGB, 32'h0000FF, "rgb_h7_blue");
      ex(8,  0, 0, F_RGB, 32'h00FF00, "rgb_h8_green");
      ex(12, 0, 0, F_RGB, 32'hFF0000, "rgb_h12_red");
      ex(15, 0, 0, F_RGB, 32'hFF0000, "rgb_h15_red");
      ex(16, 0, 0, F_RGB, 32'h9292AA, "rgb_h16_word1");
      ex(32, 0, 0, F_RGB, 32'h494955, "rgb_h32_bg");
      ex(39, 0, 0, F_RGB, 32'h494955, "rgb_h39_bg");
      ex(40, 0, 0, F_RGB, 32'h000000, "rgb_h40_blank");
      ex(55, 0, 0, F_RGB, 32'h000000, "rgb_h55_blank");
      ex(0,  0, 0, F_BLANK, 32'd1, "blank_h0");
      ex(39, 0, 0, F_BLANK, 32'd1, "blank_h39");
      ex(40, 0, 0, F_BLANK, 32'd0, "blank_h40");
      ex(55, 0, 0, F_BLANK, 32'd0, "blank_h55");
      ex(0,  1, 0, F_BLANK, 32'd1, "blank_v1_h0");
      ex(0,  1, 0, F_RGB,   32'hFFFFFF, "rgb_v1_h0");
      ex(43, 0, 0, F_HS, 32'd1, "hs_h43");
      ex(44, 0, 0, F_HS, 32'd0, "hs_h44");
      ex(51, 0, 0, F_HS, 32'd0, "hs_h51");
      ex(52, 0, 0, F_HS, 32'd1, "hs_h52");
      ex(16, 0, 0, F_ADDR, 32'h804, "addr_h16");
      ex(32, 0, 0, F_ADDR, 32'h804, "addr_h32_hold");
      ex(0,  4, 0, F_ADDR, 32'h808, "addr_v4_h0");
      ex(4,  4, 0, F_ADDR, 32'h808, "addr_v4_h4");
      ex(16, 4, 0, F_ADDR, 32'h80C, "addr_v4_h16");
      ex(0,  4, 0, F_RGB,  32'hDB2400, "rgb_v4_h0");
      ex(4,  4, 0, F_RGB,  32'h2492FF, "rgb_v4_h4");
      ex(0,  8, 0, F_ADDR, 32'h80C, "addr_v8_hold");
      ex(16, 8, 0, F_ADDR, 32'h80C, "addr_v8_h16_hold");
      ex(0,  8, 0, F_RGB,  32'h494955, "rgb_v8_bg");
      ex(0, 12, 0, F_RGB,  32'h000000, "rgb_v12");
      ex(0, 12, 0, F_BLANK, 32'd0, "blank_v12");
      ex(55, 13, 0, F_VS, 32'd1, "vs_v13_end");
      ex(0,  14, 0, F_VS, 32'd0, "vs_v14");
      ex(55, 15, 0, F_VS, 32'd0, "vs_v15_end");
      ex(0,  16, 0, F_VS, 32'd1, "vs_v16");
      push(FRAME + 1, F_FS, 32'd0, "frame_start_pre1");
      ex(0, 0, 1, F_FS,  32'd1,      "frame_start_1");
      ex(0, 0, 1, F_RGB, 32'hFFFFFF, "rgb_f1_h0");

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Mid-frame reset at (h=20, v=5) of the second frame.
      wait_tick(FRAME + 5 * HT + 20);
      flush("phase1");
      push_reset_vals();
      ex(0, 0, 0, F_ADDR, 32'h800, "restart_addr");
      ex(0, 0, 0, F_FS,   32'd1,   "restart_frame_start");
      ex(0, 0, 0, F_RGB,  32'hFFFFFF, "restart_rgb");
      push(3, F_FS, 32'd0, "restart_frame_start_off");
      ex(55, 13, 0, F_VS, 32'd1, "restart_vs_pre0");
      ex(0,  14, 0, F_VS, 32'd0, "restart_vs_fall0");
      ex(55, 13, 1, F_VS, 32'd1, "restart_vs_pre1");
      ex(0,  14, 1, F_VS, 32'd0, "restart_vs_fall1");
      ex(0,  0,  1, F_FS, 32'd1, "restart_frame_start_1");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      wait_tick(FRAME + 800);
      flush("phase2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
